mem_responder: RTL and testbench

- Bus responder serving the multi-cycle core's memory port (we/address/data_out out of the core, data_in back into it).
- Provides word RAM for instruction fetch and load/store.
- Provides a small MMIO window:
  - console TX byte FIFO drained over a valid/ready stream;
  - status register;
  - cycle counter;
  - exit register that halts the simulation and captures an exit code.

---
 rtl/mem_map_pkg.sv | 36 +++
 rtl/console_fifo.sv | 47 ++++
 rtl/mem_responder.sv | 119 +++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Shared memory-map constants for mem_responder: MMIO window base, register
// offsets, STATUS bit layout and a STATUS word packing helper.
package mem_map_pkg;

  localparam logic [31:0] MMIO_BASE_DEF = 32'h0001_0000;

  typedef enum logic [1:0] {
    OFF_TX     = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_CYCLE  = 2'd2,
    OFF_EXIT   = 2'd3
  } mmio_off_e;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic ovf, input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL_BIT]                  = full;
    w[STAT_EMPTY_BIT]                 = empty;
    w[STAT_OVF_BIT]                   = ovf;
    w[STAT_CNT_LSB+7:STAT_CNT_LSB]    = cnt;
    return w;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Console TX byte FIFO: wrap-bit pointers, push accepted when not full or
// when a pop happens in the same cycle; valid/ready drain side.
module console_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [7:0]               push_data_i,
  output logic                     push_ok_o,
  output logic                     valid_o,
  output logic [7:0]               data_o,
  input  logic                     ready_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic        pop;

  assign empty_o   = (wr_q == rd_q);
  assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o   = wr_q - rd_q;
  assign valid_o   = !empty_o;
  assign data_o    = mem_q[rd_q[AW-1:0]];
  assign pop       = valid_o && ready_i;
  assign push_ok_o = push_i && (!full_o || pop);

  // Storage needs no reset: the pointers alone define what is live.
  always_ff @(posedge clk_i) begin
    if (push_ok_o) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok_o) wr_q <= wr_q + 1'b1;
      if (pop)       rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory/MMIO responder for the multi-cycle core: word RAM plus console FIFO,
// STATUS, CYCLE and EXIT registers. CYCLE counter built only with MEM_RESPONDER_CYCLE_COUNTER_EN.
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        bus_we,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        halted,
  output logic [31:0] exit_code
);
  localparam int          IW        = $clog2(RAM_WORDS);
  localparam int          FAW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(4 * RAM_WORDS);

  bus_req_t  req;
  logic      ram_hit, mmio_hit, wr_en;
  logic [IW-1:0] ram_idx;
  mmio_off_e mmio_off;

  logic [31:0] ram_q [RAM_WORDS] = '{default: '0};
  logic        halted_q;
  logic [31:0] exit_code_q;
  logic        overflow_q, overflow_d;
  logic [31:0] cyc_val;

  logic        fifo_push, fifo_push_ok, fifo_full, fifo_empty, ovf_clr;
  logic [FAW:0] fifo_cnt;

  assign req      = '{we: bus_we, addr: bus_addr, wdata: bus_wdata};
  assign ram_hit  = (req.addr < RAM_BYTES);
  assign mmio_hit = (req.addr[31:4] == MMIO_BASE[31:4]);
  assign ram_idx  = req.addr[IW+1:2];
  assign mmio_off = mmio_off_e'(req.addr[3:2]);
  assign wr_en    = req.we && !halted_q;

  assign fifo_push = wr_en && mmio_hit && (mmio_off == OFF_TX);
  assign ovf_clr   = wr_en && mmio_hit && (mmio_off == OFF_STATUS) && req.wdata[STAT_OVF_BIT];

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (resetn),
    .push_i     (fifo_push),
    .push_data_i(req.wdata[7:0]),
    .push_ok_o  (fifo_push_ok),
    .valid_o    (con_valid),
    .data_o     (con_data),
    .ready_i    (con_ready),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // A dropped push in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_clr)                      overflow_d = 1'b0;
    if (fifo_push && !fifo_push_ok)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) ram_q[ram_idx] <= req.wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      halted_q    <= 1'b0;
      exit_code_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      if (wr_en && mmio_hit && (mmio_off == OFF_EXIT)) begin
        halted_q    <= 1'b1;
        exit_code_q <= req.wdata;
      end
    end
  end

`ifdef MEM_RESPONDER_CYCLE_COUNTER_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        cyc_q <= '0;
    else if (!halted_q) cyc_q <= cyc_q + 32'd1;
  end
  assign cyc_val = cyc_q;
`else
  assign cyc_val = '0;
`endif

  // Combinational read: a write cycle still sees the pre-write word.
  always_comb begin
    bus_rdata = '0;
    if (ram_hit) begin
      bus_rdata = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (mmio_off)
        OFF_TX:     bus_rdata = '0;
        OFF_STATUS: bus_rdata = status_word(fifo_full, fifo_empty, overflow_q, 8'(fifo_cnt));
        OFF_CYCLE:  bus_rdata = cyc_val;
        OFF_EXIT:   bus_rdata = exit_code_q;
        default:    bus_rdata = '0;
      endcase
    end
  end

  assign halted    = halted_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expectations, a negedge
// monitor compares them and checks the console stream in order.
module tb_mem_responder;
  localparam logic [31:0] MB = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        con_valid, con_ready;
  logic [7:0]  con_data;
  logic        halted;
  logic [31:0] exit_code;

  typedef enum {S_RDATA, S_HALT, S_EXIT, S_CVALID, S_CDATA, S_CONQ} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  conq[$];
  int          checks = 0;
  int          failures = 0;
  logic        rdy = 1'b0;

  mem_responder dut (
    .clk(clk), .resetn(resetn), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready), .halted(halted), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (expq.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = expq.pop_front();
      act = '0;
      case (e.sig)
        S_RDATA:  act = bus_rdata;
        S_HALT:   act = 32'(halted);
        S_EXIT:   act = exit_code;
        S_CVALID: act = 32'(con_valid);
        S_CDATA:  act = 32'(con_data);
        S_CONQ:   act = 32'(conq.size());
        default:  act = '0;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
    if (resetn && con_valid && con_ready) begin
      checks++;
      if (conq.size() == 0) begin
        failures++;
        $display("FAIL con_unexpected: got byte %h want none", con_data);
      end else begin
        logic [7:0] b;
        b = conq.pop_front();
        if (con_data !== b) begin
          failures++;
          $display("FAIL con_byte: got %h want %h", con_data, b);
        end
      end
    end
  end

  task automatic expect_v(input sig_e s, input logic [31:0] v, input string n);
    expq.push_back('{name: n, sig: s, exp: v});
  endtask

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    bus_we = we; bus_addr = a; bus_wdata = d; con_ready = rdy;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] v, input string n);
    step(1'b0, a, 32'h0);
    expect_v(S_RDATA, v, n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; con_ready = 1'b0;
    #1;
    expect_v(S_HALT, 0, "rst_halted");
    expect_v(S_EXIT, 0, "rst_exit_code");
    expect_v(S_CVALID, 0, "rst_con_valid");
    #20 resetn = 1'b1;

    rd(MB + 32'h4, 32'h0000_0002, "status_after_rst");

    wr(32'h10, 32'hDEAD_BEEF);
    expect_v(S_RDATA, 32'h0, "wr_cycle_old_word");
    rd(32'h10, 32'hDEAD_BEEF, "ram_rd_0x10");
    rd(32'h13, 32'hDEAD_BEEF, "ram_rd_0x13");

    rdy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr(MB, 32'h41 + 32'(i));
      if (i == 0) expect_v(S_RDATA, 32'h0, "tx_reads_zero");
    end
    rd(MB + 32'h4, 32'h0000_0805, "status_full_ovf");
    expect_v(S_CDATA, 32'h41, "head_byte");
    for (int i = 0; i < 8; i++) conq.push_back(8'h41 + 8'(i));
    rdy = 1'b1;
    idle(10);
    rd(MB + 32'h4, 32'h0000_0006, "status_drained_ovf");
    expect_v(S_CVALID, 0, "drained_con_valid");
    wr(MB + 32'h4, 32'h4);
    rd(MB + 32'h4, 32'h0000_0002, "status_ovf_cleared");

    rdy = 1'b0;
    for (int i = 0; i < 8; i++) wr(MB, 32'h50 + 32'(i));
    rd(MB + 32'h4, 32'h0000_0801, "status_full");
    for (int i = 0; i < 9; i++) conq.push_back(8'h50 + 8'(i));
    rdy = 1'b1;
    wr(MB, 32'h58);
    rdy = 1'b0;
    rd(MB + 32'h4, 32'h0000_0801, "full_push_pop");
    rdy = 1'b1;
    idle(10);
    rd(MB + 32'h4, 32'h0000_0002, "status_drain2");

    rd(32'h0002_0000, 32'h0, "unmapped_rd");
    wr(32'h0002_0000, 32'h1234_5678);
    wr(32'h20, 32'h1111_1111);
    rd(32'h0, 32'h0, "unmapped_no_alias");
    rd(32'h10, 32'hDEAD_BEEF, "unmapped_ram_kept");
    rd(MB + 32'h4, 32'h0000_0002, "unmapped_status_kept");
    rd(MB + 32'hC, 32'h0, "exit_before");

    wr(MB + 32'hC, 32'h0000_002A);
    expect_v(S_HALT, 0, "halt_same_cycle");
    idle(1);
    expect_v(S_HALT, 1, "halted_set");
    expect_v(S_EXIT, 32'd42, "exit_code_42");
    rd(MB + 32'hC, 32'h0000_002A, "exit_rd");
`ifndef MEM_RESPONDER_CYCLE_COUNTER_EN
    rd(MB + 32'h8, 32'h0, "cycle_disabled");
`endif
    wr(32'h20, 32'hBAD0_BAD0);
    rd(32'h20, 32'h1111_1111, "halt_ram_blocked");
    rdy = 1'b0;
    wr(MB, 32'h77);
    rd(MB + 32'h4, 32'h0000_0002, "halt_tx_blocked");
    wr(MB + 32'hC, 32'h99);
    rd(MB + 32'hC, 32'h0000_002A, "exit_held");
    expect_v(S_HALT, 1, "halt_sticky");
`ifndef MEM_RESPONDER_CYCLE_COUNTER_EN
    rd(MB + 32'h8, 32'h0, "cycle_disabled2");
`endif

    @(posedge clk); #1;
    bus_we = 1'b0; resetn = 1'b0;
    expect_v(S_HALT, 0, "rst2_halted");
    expect_v(S_EXIT, 0, "rst2_exit_code");
    #10 resetn = 1'b1;

    rdy = 1'b0;
    wr(MB, 32'h61);
    wr(MB, 32'h62);
    wr(MB, 32'h63);
    conq.push_back(8'h61);
    rdy = 1'b1;
    idle(1);
    @(posedge clk); #2;
    resetn = 1'b0; rdy = 1'b0; con_ready = 1'b0;
    expect_v(S_CVALID, 0, "rst_mid_drain_valid");
    #10 resetn = 1'b1;
    rd(MB + 32'h4, 32'h0000_0002, "status_after_rst2");
    rd(32'h10, 32'hDEAD_BEEF, "ram_retained");
    expect_v(S_CONQ, 0, "con_all_seen");
    idle(1);
    @(negedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
